hop_chain_mc: RTL
=================

// Module: hop_chain_mc
// PURPOSE
//  - Parametrised multi-channel registered hop chain: NUM_CH independent lanes, each a DEPTH-stage shift pipeline carrying WIDTH-bit data plus a valid bit.
//  - Generalises the fixed 4-lane x 5-stage single-bit chains with per-flop resets: adds per-lane advance enable, per-stage synchronous clear, lane flush FSM and delivered-word counters.
//  - Sits between stimulus sources and timing/placement probe points in hop micro-benchmarks.
// PARAMETERS
//  - NUM_CH  4   number of independent lanes (1..16)
//  - DEPTH   5   stages per lane (2..32)
//  - WIDTH   1   data bits per stage (1..64)
//  - CNT_W   8   width of per-lane delivered-word counter (saturating)
// PORTS
//  - clock0       in   1             single clock, all flops rising-edge
//  - rst_n        in   1             asynchronous, active-low reset
//  - in_valid     in   NUM_CH        lane c head-stage valid (start)
//  - in_data      in   NUM_CH*WIDTH  lane c data, slice [c*WIDTH +: WIDTH]
//  - ch_en        in   NUM_CH        lane advance enable; 0 = lane holds
//  - stage_clr    in   NUM_CH*DEPTH  sync clear of stage s of lane c, bit [c*DEPTH+s]
//  - ch_flush     in   NUM_CH        request lane drain (pulse or level)
//  - out_valid    out  NUM_CH        valid of last stage of lane c
//  - out_data     out  NUM_CH*WIDTH  data of last stage of lane c
//  - ch_busy      out  NUM_CH        any stage of lane c valid, or lane in FLUSH
//  - ch_count     out  NUM_CH*CNT_W  words delivered by lane c
// BEHAVIOUR
//  - Reset (rst_n=0, async): all stage valid/data=0, counters=0, FSMs=IDLE; hence out_valid=0, out_data=0, ch_busy=0, ch_count=0. Reset mid-operation discards in-flight words immediately.
//  - Lane FSM states IDLE, RUN, FLUSH. IDLE->RUN when ch_en=1 and in_valid=1; RUN->IDLE when no stage valid and in_valid=0; any->FLUSH on ch_flush=1; FLUSH->IDLE after exactly DEPTH cycles with ch_flush=0 (flush re-asserted restarts the DEPTH count).
//  - Shift (RUN/IDLE, ch_en=1): stage0<=in_valid/in_data; stage s<=stage s-1. ch_en=0: all stages hold; in_valid ignored.
//  - FLUSH: shifts every cycle regardless of ch_en, head loads valid=0 data=0; in_valid ignored; out_valid forced 0 (drained words not delivered, not counted).
//  - Latency: word on in_data at edge N appears on out_data after edge N+DEPTH-1 when ch_en held 1 (visible DEPTH cycles incl. capture cycle: out at cycle N+DEPTH-1 registered).
//  - Priority per stage per cycle: rst_n > FLUSH > stage_clr > shift/hold. stage_clr sets that stage valid=0 data=0 for the cycle in which the shift would load it; other stages shift normally.
//  - ch_count increments by 1 on each cycle out_valid=1 and ch_en=1 (word consumed); saturates at 2^CNT_W-1, never wraps.
//  - Lanes fully independent; simultaneous flush of one lane does not disturb others.
//  - Data bits are unchanged in transit; invalid stages always carry data=0.
// CONFIGURATION
//  - HOP_TAP_EN defined: extra ports tap_sel in $clog2(DEPTH) (shared) and tap_data out NUM_CH*WIDTH, tap_valid out NUM_CH; tap = registered copy of stage tap_sel of each lane (one extra cycle latency); tap_sel >= DEPTH yields tap_valid=0, tap_data=0; reset value 0.
//  - HOP_TAP_EN undefined: tap ports and logic absent; all other behaviour identical.
// STRUCTURE
//  - Package hop_pkg: lane_state_t enum {IDLE, RUN, FLUSH}; localparam FLUSH_CNT_W = $clog2(DEPTH+1); sat_inc function for CNT_W counters.
//  - Sub-module hop_chain_lane: one lane (stages, FSM, flush counter, delivered counter); top instantiates NUM_CH via generate and slices buses.
// TESTING (NUM_CH=4, DEPTH=5, WIDTH=8, CNT_W=8 unless stated)
//  - Reset: hold rst_n=0 with in_valid=4'hF -> all outputs 0; release, drive lane0 0xA5 valid one cycle -> out_valid[0]=1, out_data=0xA5 exactly DEPTH-1 edges later, one cycle wide.
//  - Stall: lane1 stream 0x01..0x05, drop ch_en[1] 3 cycles mid-stream -> order preserved, delivery delayed 3 cycles, ch_count[1]=5, lanes 0/2/3 unaffected.
//  - Stage clear: lane2 stream 0x10..0x14, pulse stage_clr[2*5+2] when 0x12 is loaded into stage 2 -> 0x12 never appears, ch_count[2]=4.
//  - Flush: lane3 full of 5 words, assert ch_flush[3] one cycle -> out_valid[3]=0 for 5 cycles, ch_busy[3] high 5 cycles then 0, ch_count[3] unchanged, in_valid ignored meanwhile.
//  - Saturation: CNT_W=3, deliver 10 words on lane0 -> ch_count[0] stops at 7.
//  - HOP_TAP_EN: tap_sel=2, lane0 word 0x3C -> tap_valid[0]=1, tap_data=0x3C one cycle after it enters stage 2; tap_sel=7 -> tap outputs 0.

Source files
------------

// File: rtl/hop_pkg.sv
// Shared types and helpers for the multi-lane hop chain.
// Lane FSM states, flush-counter sizing and a saturating increment.
package hop_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } lane_state_t;

  localparam int DEF_DEPTH   = 5;
  localparam int FLUSH_CNT_W = $clog2(DEF_DEPTH + 1);

  function automatic logic [63:0] sat_inc(
    input logic [63:0] v,
    input logic [63:0] max_v
  );
    return (v >= max_v) ? v : v + 64'd1;
  endfunction

endpackage

// File: rtl/hop_chain_lane.sv
// One hop lane: DEPTH-stage valid/data shift chain, flush FSM, delivery counter.
// HOP_TAP_EN adds a registered tap of a selectable stage.
module hop_chain_lane
  import hop_pkg::*;
#(
  parameter int DEPTH = 5,
  parameter int WIDTH = 1,
  parameter int CNT_W = 8,
  parameter int TAP_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             ch_en,
  input  logic [DEPTH-1:0] stage_clr,
  input  logic             ch_flush,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic [CNT_W-1:0] count
`ifdef HOP_TAP_EN
  ,
  input  logic [TAP_W-1:0] tap_sel,
  output logic             tap_valid,
  output logic [WIDTH-1:0] tap_data
`endif
);

  localparam int FW_D = $clog2(DEPTH + 1);
  localparam int FW   = (FLUSH_CNT_W > FW_D) ? FLUSH_CNT_W : FW_D;
  localparam logic [CNT_W-1:0] CMAX = '1;

  lane_state_t      state, state_nx;
  logic [FW-1:0]    fcnt, fcnt_nx;
  logic [DEPTH-1:0] v_q, v_nx, src_v;
  logic [WIDTH-1:0] d_q [DEPTH];
  logic [WIDTH-1:0] d_nx [DEPTH];
  logic [WIDTH-1:0] src_d [DEPTH];
  logic             flushing;
  logic             head_v;
  logic [WIDTH-1:0] head_d;

  assign flushing = (state == FLUSH);
  assign head_v   = ~flushing & in_valid;
  assign head_d   = head_v ? in_data : '0;

  always_comb begin
    src_v    = {v_q[DEPTH-2:0], head_v};
    src_d    = d_q;
    src_d[0] = head_d;
    for (int s = 1; s < DEPTH; s++) begin
      src_d[s] = d_q[s-1];
    end
  end

  // Flush outranks stage clear, which outranks shift/hold.
  always_comb begin
    v_nx = v_q;
    d_nx = d_q;
    for (int s = 0; s < DEPTH; s++) begin
      if (flushing) begin
        v_nx[s] = src_v[s];
        d_nx[s] = src_d[s];
      end else if (stage_clr[s]) begin
        v_nx[s] = 1'b0;
        d_nx[s] = '0;
      end else if (ch_en) begin
        v_nx[s] = src_v[s];
        d_nx[s] = src_d[s];
      end
    end
  end

  always_comb begin
    state_nx = state;
    fcnt_nx  = fcnt;
    if (ch_flush) begin
      state_nx = FLUSH;
      fcnt_nx  = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (ch_en && in_valid) state_nx = RUN;
        end
        RUN: begin
          if (~|v_q && !in_valid) state_nx = IDLE;
        end
        FLUSH: begin
          if (fcnt == FW'(DEPTH - 1)) begin
            state_nx = IDLE;
            fcnt_nx  = '0;
          end else begin
            fcnt_nx = fcnt + FW'(1);
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  assign out_valid = v_q[DEPTH-1] & ~flushing;
  assign out_data  = out_valid ? d_q[DEPTH-1] : '0;
  assign busy      = (|v_q) | flushing;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      fcnt  <= '0;
      v_q   <= '0;
      count <= '0;
      for (int s = 0; s < DEPTH; s++) begin
        d_q[s] <= '0;
      end
    end else begin
      state <= state_nx;
      fcnt  <= fcnt_nx;
      v_q   <= v_nx;
      d_q   <= d_nx;
      if (out_valid && ch_en) begin
        count <= CNT_W'(sat_inc(64'(count), 64'(CMAX)));
      end
    end
  end

`ifdef HOP_TAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tap_valid <= 1'b0;
      tap_data  <= '0;
    end else if (32'(tap_sel) < DEPTH) begin
      tap_valid <= v_q[tap_sel];
      tap_data  <= d_q[tap_sel];
    end else begin
      tap_valid <= 1'b0;
      tap_data  <= '0;
    end
  end
`endif

endmodule

// File: rtl/hop_chain_mc.sv
// NUM_CH independent registered hop lanes with flush, clear and counters.
// Optional stage tap when HOP_TAP_EN is defined.
module hop_chain_mc
  import hop_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DEPTH  = 5,
  parameter int WIDTH  = 1,
  parameter int CNT_W  = 8
) (
  input  logic                    clock0,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       in_valid,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic [NUM_CH*DEPTH-1:0] stage_clr,
  input  logic [NUM_CH-1:0]       ch_flush,
  output logic [NUM_CH-1:0]       out_valid,
  output logic [NUM_CH*WIDTH-1:0] out_data,
  output logic [NUM_CH-1:0]       ch_busy,
  output logic [NUM_CH*CNT_W-1:0] ch_count
`ifdef HOP_TAP_EN
  ,
  input  logic [$clog2(DEPTH)-1:0] tap_sel,
  output logic [NUM_CH*WIDTH-1:0]  tap_data,
  output logic [NUM_CH-1:0]        tap_valid
`endif
);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    hop_chain_lane #(
      .DEPTH (DEPTH),
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
    ) u_lane (
      .clk       (clock0),
      .rst_n     (rst_n),
      .in_valid  (in_valid[c]),
      .in_data   (in_data[c*WIDTH +: WIDTH]),
      .ch_en     (ch_en[c]),
      .stage_clr (stage_clr[c*DEPTH +: DEPTH]),
      .ch_flush  (ch_flush[c]),
      .out_valid (out_valid[c]),
      .out_data  (out_data[c*WIDTH +: WIDTH]),
      .busy      (ch_busy[c]),
      .count     (ch_count[c*CNT_W +: CNT_W])
`ifdef HOP_TAP_EN
      ,
      .tap_sel   (tap_sel),
      .tap_valid (tap_valid[c]),
      .tap_data  (tap_data[c*WIDTH +: WIDTH])
`endif
    );
  end

endmodule
